// File: rtl/serial_adder_ctrl_if.sv
// serial_adder_ctrl_if: request-side operands/results plus the shared 1-bit full adder hookup.
// The sub port exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_ctrl_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Carry_in;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             fa_A;
    logic             fa_B;
    logic             fa_Carry_in;
    logic             fa_SUM;
    logic             fa_Carry_out;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] SUM;
    logic             Carry_out;

    modport slave (
        input  start, A, B, Carry_in,
`ifdef SERIAL_ADDER_SUB_EN
        input  sub,
`endif
        input  fa_SUM, fa_Carry_out,
        output fa_A, fa_B, fa_Carry_in, busy, done, SUM, Carry_out
    );

    modport master (
        output start, A, B, Carry_in,
`ifdef SERIAL_ADDER_SUB_EN
        output sub,
`endif
        output fa_SUM, fa_Carry_out,
        input  fa_A, fa_B, fa_Carry_in, busy, done, SUM, Carry_out
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder sequencer driving one shared external full adder, LSB first.
// Optional subtract mode (A - B via ~B and carry 1) is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input logic              clk,
    input logic              reset,
    serial_adder_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sha_q, sha_d, shb_q, shb_d, res_q, res_d, sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d, co_q, co_d, busy_q, busy_d, done_q, done_d;
    logic [WIDTH-1:0] b_load;
    logic             c_load;

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction is A + ~B + 1; Carry_out=1 then means no borrow.
    assign b_load = bus.sub ? ~bus.B : bus.B;
    assign c_load = bus.sub | bus.Carry_in;
`else
    assign b_load = bus.B;
    assign c_load = bus.Carry_in;
`endif

    always_comb begin
        state_d = state_q;
        sha_d   = sha_q;
        shb_d   = shb_q;
        res_d   = res_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        co_d    = co_q;
        cnt_d   = cnt_q;
        if (state_q == RUN) begin
            carry_d       = bus.fa_Carry_out;
            res_d[cnt_q]  = bus.fa_SUM;
            sha_d         = sha_q >> 1;
            shb_d         = shb_q >> 1;
            cnt_d         = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
                sum_d   = res_d;
                co_d    = bus.fa_Carry_out;
                state_d = DONE;
            end
        end else if (bus.start) begin
            sha_d   = bus.A;
            shb_d   = b_load;
            carry_d = c_load;
            cnt_d   = '0;
            state_d = RUN;
        end else begin
            state_d = IDLE;
        end
        busy_d = state_d == RUN;
        done_d = state_d == DONE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sha_q   <= '0;
            shb_q   <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sha_q   <= sha_d;
            shb_q   <= shb_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            co_q    <= co_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.fa_A        = busy_q & sha_q[0];
    assign bus.fa_B        = busy_q & shb_q[0];
    assign bus.fa_Carry_in = busy_q & carry_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.SUM         = sum_q;
    assign bus.Carry_out   = co_q;
endmodule
